// File: rtl/adder_seq_chunk.sv
// Multi-cycle ripple adder: operands are latched on start and summed CHUNK bits per clock.
// Define ADDER_OVERFLOW_EN to add the signed-overflow output ovf.
module adder_seq_chunk #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) ||
            ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_params
            $error("adder_seq_chunk: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last_chunk;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [CHUNK:0]   w_add;

    // CHUNK+1 bit addition; the MSB of the result is the carry out of the chunk.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             c
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    endfunction

    assign w_add        = chunk_add(r_x[CHUNK-1:0], r_y[CHUNK-1:0], r_carry);
    assign w_last_chunk = (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last_chunk) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operands shift right so the active chunk is always in the low CHUNK bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_x     <= x;
            r_y     <= y;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_x     <= r_x >> CHUNK;
            r_y     <= r_y >> CHUNK;
            r_carry <= w_add[CHUNK];
            r_cnt   <= r_cnt + CNT_W'(1);
            for (int i = 0; i < N; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_sum[i*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
                end
            end
            if (w_last_chunk) begin
                r_cout <= w_add[CHUNK];
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    logic r_ovf;

    // Carry into the MSB equals a ^ b ^ s at that bit, so ovf = a ^ b ^ s ^ carry-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == RUN) && w_last_chunk && !w_accept) begin
            r_ovf <= r_x[CHUNK-1] ^ r_y[CHUNK-1] ^ w_add[CHUNK-1] ^ w_add[CHUNK];
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_adder_seq_chunk.sv
// Directed bench for adder_seq_chunk: default instance plus CHUNK=32/1/4 instances sharing the inputs.
module tb_adder_seq_chunk;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;

    logic        busy, done, cout;
    logic [31:0] sum;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;
    logic        busy1, done1, cout1;
    logic [31:0] sum1;
    logic        busy4, done4, cout4;
    logic [31:0] sum4;
`ifdef ADDER_OVERFLOW_EN
    logic        ovf, ovf32, ovf1, ovf4;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int g_lat;
    int g_busy;

    adder_seq_chunk dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    adder_seq_chunk #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf32)
`endif
    );

    adder_seq_chunk #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    adder_seq_chunk #(.WIDTH(32), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; leaves time at #1 after the done edge.
    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        x = a; y = b; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        g_lat  = 0;
        g_busy = 0;
        while (done !== 1'b1 && g_lat < 100) begin
            if (busy === 1'b1) g_busy++;
            @(posedge clk); #1;
            g_lat++;
        end
    endtask

    initial begin
        int l8, l32, l1, l4;
        bit seen;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum",  sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;

        op(32'd5000, 32'd10200, 1'b0);
        chk("t1_lat",  g_lat, 4);
        chk("t1_busy_cycles", g_busy, 4);
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_sum",  sum, 32'd15200);
        chk("t1_cout", cout, 0);
        @(posedge clk); #1;
        chk("t1_done_once", done, 0);
        chk("t1_sum_hold", sum, 32'd15200);

        op(32'd5000, 32'd10207, 1'b1);
        chk("t2_sum",  sum, 32'd15208);
        chk("t2_cout", cout, 0);
        op(32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("t2_ripple_lat",  g_lat, 4);
        chk("t2_ripple_sum",  sum, 0);
        chk("t2_ripple_cout", cout, 1);

        // Start while busy is ignored; then restart in the DONE cycle.
        @(negedge clk);
        x = 32'd1; y = 32'd1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        x = 32'd7; y = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("t3_busy_mid", busy, 1);
        @(posedge clk); #1;
        chk("t3_done_lat", done, 1);
        chk("t3_sum", sum, 32'd2);
        x = 32'd3; y = 32'd4; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("t3_b2b_busy", busy, 1);
        chk("t3_b2b_done_low", done, 0);
        g_lat = 0;
        while (done !== 1'b1 && g_lat < 100) begin
            @(posedge clk); #1;
            g_lat++;
        end
        chk("t3_b2b_lat", g_lat, 4);
        chk("t3_b2b_sum", sum, 32'd7);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        x = 32'h1111_1111; y = 32'h2222_2222; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_partial", sum[15:0], 16'h3333);
        rst = 1'b1;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_sum",  sum, 0);
        chk("t4_cout", cout, 0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("t4_no_done", seen, 0);
        op(32'd0, 32'd1, 1'b1);
        chk("t4_fresh_sum", sum, 32'd2);
        chk("t4_fresh_lat", g_lat, 4);

        // Parameter sweep: all instances start together.
        repeat (40) @(posedge clk);
        @(negedge clk);
        x = 32'h89AB_CDEF; y = 32'h7654_3210; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        l8 = 0; l32 = 0; l1 = 0; l4 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done   === 1'b1 && l8  == 0) l8  = k;
            if (done32 === 1'b1 && l32 == 0) l32 = k;
            if (done1  === 1'b1 && l1  == 0) l1  = k;
            if (done4  === 1'b1 && l4  == 0) l4  = k;
        end
        chk("sw_lat_c8",  l8, 4);
        chk("sw_lat_c32", l32, 1);
        chk("sw_lat_c1",  l1, 32);
        chk("sw_lat_c4",  l4, 8);
        chk("sw_sum_c8",  sum, 0);
        chk("sw_sum_c32", sum32, 0);
        chk("sw_sum_c1",  sum1, 0);
        chk("sw_sum_c4",  sum4, 0);
        chk("sw_cout_c8",  cout, 1);
        chk("sw_cout_c32", cout32, 1);
        chk("sw_cout_c1",  cout1, 1);
        chk("sw_cout_c4",  cout4, 1);

`ifdef ADDER_OVERFLOW_EN
        op(32'h7FFF_FFFF, 32'd1, 1'b0);
        chk("ovf_pos_ovf",  ovf, 1);
        chk("ovf_pos_cout", cout, 0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_neg_ovf",  ovf, 1);
        chk("ovf_neg_cout", cout, 1);
        chk("ovf_neg_sum",  sum, 32'h7FFF_FFFF);
        op(32'd5, 32'd3, 1'b0);
        chk("ovf_none", ovf, 0);
        chk("ovf_none_sum", sum, 32'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_seq_chunk.md
Name: adder_seq_chunk

Overview:
Parametrised multi-cycle ripple adder and the sequential successor of the 32-bit combinational adder. Operands are latched on a start strobe and summed CHUNK bits per clock, with the carry held in a register between chunks. The result is reported with a done pulse. Intended for wide datapaths where a single-cycle WIDTH-bit carry chain misses timing.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per clock; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
x  input  WIDTH  operand A, unsigned (two's complement for the overflow feature).
y  input  WIDTH  operand B.
cin  input  1  carry-in to bit 0.
busy  output  1  high while a sum is in progress.
done  output  1  one-cycle pulse: sum/cout valid.
sum  output  WIDTH  x+y+cin, low WIDTH bits.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Let N = WIDTH/CHUNK. The state machine has three states: IDLE, RUN, DONE.
- Reset (rst=1, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - The chunk counter, carry register and operand shift registers are cleared.
  - Any operation in progress is discarded, with no done pulse.
- IDLE or DONE, start=1 at edge E0:
  - Latch x, y and cin.
  - Clear sum.
  - Set counter=0, state=RUN, busy=1, done=0.
- IDLE or DONE, start=0: stay in the current state. DONE returns to IDLE after one cycle.
- RUN, each edge Ek (k=1..N):
  - Add chunk k-1 (bits [k*CHUNK-1:(k-1)*CHUNK]) plus the carry register.
  - Write the CHUNK-bit result into the same slice of sum.
  - Update the carry register and increment the counter.
  - Chunk 0 uses the latched cin.
- At EN:
  - cout = final carry.
  - state=DONE, busy=0, done=1 for exactly one cycle.
- Latency: done is high in the cycle after edge EN. That is N cycles after the start edge (4 at the defaults; 1 when CHUNK=WIDTH).
- start while busy=1 is ignored, not queued; operands are taken only at E0.
- Back-to-back operation: start=1 during the DONE cycle is accepted. The next RUN begins immediately, so throughput is one result per N+1 cycles.
- sum and cout hold their value from EN until the next accepted start or reset.
- Width rules:
  - All additions are CHUNK+1 bits wide; the MSB is the carry.
  - Carry out of the top chunk goes to cout only; no wrap into bit 0.
- sum slices are visible while they are being built. The full value is valid only when done=1 or afterwards.
- Illegal parameters (WIDTH % CHUNK != 0, or CHUNK=0) must stop elaboration.

Optional Feature:
ADDER_OVERFLOW_EN
- Defined:
  - Adds an output port ovf (1 bit).
  - ovf = signed overflow, computed as carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Updated at EN, held like cout, and reset to 0.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; rst pulse, then start with x=5000, y=10200, cin=0 -> busy=1 for 4 cycles; done pulses once; sum=15200, cout=0.
- start with x=5000, y=10207, cin=1 -> sum=15208, cout=0. Then x=32'hFFFFFFFF, y=1, cin=0 -> sum=0, cout=1; carry must ripple through all 4 chunks.
- Start x=1, y=1, then assert start with x=7, y=7 two cycles later (busy=1) -> second request ignored; result sum=2 at the original latency. Then start in the DONE cycle with x=3, y=4 -> sum=7 exactly 4 cycles later.
- Assert rst after 2 RUN cycles -> all outputs 0 immediately (asynchronous); no done pulse; a fresh start with x=0, y=1, cin=1 yields sum=2.
- Parameter sweep: WIDTH=32 with CHUNK=32, 1 and 4, operands x=32'h89ABCDEF, y=32'h76543210, cin=1 -> latency 1, 32 and 8 cycles respectively; sum=0, cout=1 in every case.
- ADDER_OVERFLOW_EN defined: x=32'h7FFFFFFF, y=1 -> ovf=1, cout=0. Then x=32'h80000000, y=32'hFFFFFFFF -> ovf=1, cout=1. Then x=5, y=3 -> ovf=0.
